// File: rtl/dev_dumper.sv
// Dumps a RAM region to the tx_pipe as uppercase ASCII hex text, one line per BYTES_PER_LINE bytes.
// Optional macro DEV_DUMPER_ADDR_PREFIX_EN prefixes each line with "AAAA: ".
module dev_dumper #(
    parameter int ADDR_W         = 16,
    parameter int LEN_W          = 16,
    parameter int BYTES_PER_LINE = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_fetch,
    input  logic [7:0]        ram_data,
    output logic [7:0]        tx_data,
    output logic              tx_push,
    input  logic              tx_full
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FETCH = 4'd1;
    localparam logic [3:0] S_WAIT  = 4'd2;
    localparam logic [3:0] S_HI    = 4'd3;
    localparam logic [3:0] S_LO    = 4'd4;
    localparam logic [3:0] S_SEP   = 4'd5;
    localparam logic [3:0] S_NL    = 4'd6;
    localparam logic [3:0] S_FIN   = 4'd7;

    localparam logic [LEN_W-1:0]  BPL_MASK = LEN_W'(BYTES_PER_LINE - 1);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    localparam logic [3:0] S_ADDR = 4'd8;
    localparam int         ND     = (ADDR_W + 3) / 4;
    localparam int         DIG_W  = $clog2(ND + 2) + 1;
    localparam logic [DIG_W-1:0] ND_D     = DIG_W'(ND);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(ND + 1);
    localparam logic [DIG_W-1:0] DIG_ONE  = DIG_W'(1);
`endif

    logic [3:0]        state_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  cnt_r;
    logic [7:0]        byte_r;
    logic [7:0]        tx_data_r;
    logic              gap_r;
    logic              emit_s;
    logic              tx_push_s;
    logic [LEN_W-1:0]  k_s;
    logic              line_end_s;
    logic [ADDR_W-1:0] next_addr_s;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    logic [DIG_W-1:0]  dig_r;
    logic [DIG_W-1:0]  dig_next_s;
`endif

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

`ifdef DEV_DUMPER_ADDR_PREFIX_EN
    function automatic logic [7:0] addr_digit(input logic [ADDR_W-1:0] a, input logic [DIG_W-1:0] idx);
        logic [ND*4-1:0] p;
        p = '0;
        p[ADDR_W-1:0] = a;
        return hex_char(p[(ND - 1 - int'(idx)) * 4 +: 4]);
    endfunction
`endif

    // Character states push only on a non-gap cycle with room in the FIFO.
    always_comb begin
        emit_s = (state_r == S_HI) || (state_r == S_LO) || (state_r == S_SEP) || (state_r == S_NL);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
        emit_s = emit_s || (state_r == S_ADDR);
        dig_next_s = dig_r + DIG_ONE;
`endif
        tx_push_s   = emit_s && !gap_r && !tx_full;
        k_s         = cnt_r + LEN_ONE;
        line_end_s  = (k_s == len_r) || ((k_s & BPL_MASK) == {LEN_W{1'b0}});
        next_addr_s = ram_addr_r + ADDR_ONE;
    end

    assign tx_push   = tx_push_s;
    assign tx_data   = tx_data_r;
    assign ram_addr  = ram_addr_r;
    assign ram_fetch = (state_r == S_FETCH) || (state_r == S_WAIT);
    assign busy      = (state_r != S_IDLE) && (state_r != S_FIN);
    assign done      = (state_r == S_FIN);

    // Dump sequencer: each pushed char is followed by a gap cycle that advances the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            ram_addr_r <= {ADDR_W{1'b0}};
            len_r      <= {LEN_W{1'b0}};
            cnt_r      <= {LEN_W{1'b0}};
            byte_r     <= 8'h00;
            tx_data_r  <= 8'h00;
            gap_r      <= 1'b0;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
            dig_r      <= {DIG_W{1'b0}};
`endif
        end else begin
            if (tx_push_s) begin
                gap_r <= 1'b1;
            end else begin
                gap_r <= 1'b0;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        if (len == {LEN_W{1'b0}}) begin
                            state_r <= S_FIN;
                        end else begin
                            ram_addr_r <= base_addr;
                            len_r      <= len;
                            cnt_r      <= {LEN_W{1'b0}};
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
                            dig_r      <= {DIG_W{1'b0}};
                            tx_data_r  <= addr_digit(base_addr, {DIG_W{1'b0}});
                            state_r    <= S_ADDR;
`else
                            state_r    <= S_FETCH;
`endif
                        end
                    end
                end
                S_FETCH: state_r <= S_WAIT;
                S_WAIT: begin
                    byte_r    <= ram_data;
                    tx_data_r <= hex_char(ram_data[7:4]);
                    state_r   <= S_HI;
                end
                S_HI: begin
                    if (gap_r) begin
                        tx_data_r <= hex_char(byte_r[3:0]);
                        state_r   <= S_LO;
                    end
                end
                S_LO: begin
                    if (gap_r) begin
                        cnt_r <= k_s;
                        if (line_end_s) begin
                            tx_data_r <= 8'h0A;
                            state_r   <= S_NL;
                        end else begin
                            tx_data_r <= 8'h20;
                            state_r   <= S_SEP;
                        end
                    end
                end
                S_SEP: begin
                    if (gap_r) begin
                        ram_addr_r <= next_addr_s;
                        state_r    <= S_FETCH;
                    end
                end
                S_NL: begin
                    if (gap_r) begin
                        if (cnt_r == len_r) begin
                            state_r <= S_FIN;
                        end else begin
                            ram_addr_r <= next_addr_s;
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
                            dig_r      <= {DIG_W{1'b0}};
                            tx_data_r  <= addr_digit(next_addr_s, {DIG_W{1'b0}});
                            state_r    <= S_ADDR;
`else
                            state_r    <= S_FETCH;
`endif
                        end
                    end
                end
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
                S_ADDR: begin
                    if (gap_r) begin
                        if (dig_r == DIG_LAST) begin
                            state_r <= S_FETCH;
                        end else begin
                            dig_r <= dig_next_s;
                            if (dig_next_s < ND_D) begin
                                tx_data_r <= addr_digit(ram_addr_r, dig_next_s);
                            end else if (dig_next_s == ND_D) begin
                                tx_data_r <= 8'h3A;
                            end else begin
                                tx_data_r <= 8'h20;
                            end
                        end
                    end
                end
`endif
                S_FIN:   state_r <= S_IDLE;
                default: state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dev_dumper.sv
// Directed self-checking bench for dev_dumper: RAM model, tx capture, stall/reset/wrap cases.
module tb_dev_dumper;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] ram_addr;
    logic        ram_fetch;
    logic [7:0]  ram_data;
    logic [7:0]  tx_data;
    logic        tx_push;
    logic        tx_full;

    logic [7:0] mem [0:65535];
    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         done_cnt = 0;
    int         b2b_cnt  = 0;
    logic       prev_push = 1'b0;

    logic [7:0] lit1 [9] = '{8'h30, 8'h41, 8'h20, 8'h46, 8'h46, 8'h20, 8'h30, 8'h30, 8'h0A};
    logic [7:0] lit6 [6] = '{8'h31, 8'h32, 8'h20, 8'h33, 8'h34, 8'h0A};
    logic [7:0] litp [12] = '{8'h30, 8'h30, 8'h31, 8'h30, 8'h3A, 8'h20,
                              8'h41, 8'h42, 8'h20, 8'h43, 8'h44, 8'h0A};

    dev_dumper dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_fetch (ram_fetch),
        .ram_data  (ram_data),
        .tx_data   (tx_data),
        .tx_push   (tx_push),
        .tx_full   (tx_full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_data <= mem[ram_addr];
    end

    always @(posedge clk) begin
        if (tx_push) begin
            cap.push_back(tx_data);
            if (prev_push) b2b_cnt++;
        end
        if (done) done_cnt++;
        prev_push <= tx_push;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic build_exp(input logic [15:0] b, input int n);
        string hx = "0123456789ABCDEF";
        logic [15:0] a;
        logic [7:0]  v;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            a = b + 16'(i);
`ifdef DEV_DUMPER_ADDR_PREFIX_EN
            if (i % 16 == 0) begin
                for (int d = 3; d >= 0; d--) exp_q.push_back(hx[a[d*4 +: 4]]);
                exp_q.push_back(8'h3A);
                exp_q.push_back(8'h20);
            end
`endif
            v = mem[a];
            exp_q.push_back(hx[v[7:4]]);
            exp_q.push_back(hx[v[3:0]]);
            exp_q.push_back(((i + 1) == n || (i + 1) % 16 == 0) ? 8'h0A : 8'h20);
        end
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk($sformatf("%s_len", tag), cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s[%0d]", tag, i), cap[i], exp_q[i]);
    endtask

    task automatic run_dump(input logic [15:0] b, input logic [15:0] l,
                            input int stall_at, input int restart_at, output int lat);
        int   cnt;
        int   snap;
        logic busy_ok;
        cap.delete();
        done_cnt = 0;
        b2b_cnt  = 0;
        snap     = 0;
        @(negedge clk);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cnt     = 0;
        busy_ok = 1'b1;
        while (!done && cnt < 5000) begin
            if (restart_at >= 0 && cnt == restart_at) begin
                start     = 1'b1;
                base_addr = b + 16'h0040;
                len       = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (stall_at >= 0 && cnt == stall_at) begin
                tx_full = 1'b1;
                snap    = cap.size();
            end
            if (stall_at >= 0 && cnt > stall_at && cnt <= stall_at + 50 && !busy) busy_ok = 1'b0;
            if (stall_at >= 0 && cnt == stall_at + 50) begin
                chk("stall_nopush", cap.size(), snap);
                chk("stall_busy", busy_ok, 1'b1);
                tx_full = 1'b0;
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        chk("done_in_time", cnt < 5000, 1'b1);
        lat = cnt;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        int nl;
        int snap_n;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst_n     = 1'b0;
        start     = 1'b0;
        tx_full   = 1'b0;
        base_addr = 16'h0000;
        len       = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_push", tx_push, 1'b0);
        chk("rst_fetch", ram_fetch, 1'b0);
        chk("rst_addr", ram_addr, 16'h0000);
        chk("rst_data", tx_data, 8'h00);
        rst_n = 1'b1;

        // three bytes, one line
        mem[0] = 8'h0A; mem[1] = 8'hFF; mem[2] = 8'h00;
        build_exp(16'h0000, 3);
        run_dump(16'h0000, 16'd3, -1, -1, lat);
        cmp_stream("t1");
`ifndef DEV_DUMPER_ADDR_PREFIX_EN
        for (int i = 0; i < 9; i++) chk($sformatf("t1_lit[%0d]", i), cap[i], lit1[i]);
        chk("t1_cycles", lat, 24);
`endif
        chk("t1_done", done_cnt, 1);
        chk("t1_b2b", b2b_cnt, 0);

        // 17 bytes crosses a line boundary
        for (int i = 0; i < 17; i++) mem[i] = 8'(i);
        build_exp(16'h0000, 17);
        run_dump(16'h0000, 16'd17, -1, -1, lat);
        cmp_stream("t2");
        nl = 0;
        foreach (cap[i]) if (cap[i] == 8'h0A) nl++;
        chk("t2_newlines", nl, 2);
`ifndef DEV_DUMPER_ADDR_PREFIX_EN
        chk("t2_nl16", cap[47], 8'h0A);
        chk("t2_nl17", cap[50], 8'h0A);
        chk("t2_cycles", lat, 136);
`endif

        // backpressure for 50 cycles must not change the stream
        run_dump(16'h0000, 16'd17, 20, -1, lat);
        cmp_stream("t3");
        chk("t3_done", done_cnt, 1);
        chk("t3_b2b", b2b_cnt, 0);

        // zero length
        run_dump(16'h0000, 16'd0, -1, -1, lat);
        chk("t4_pushes", cap.size(), 0);
        chk("t4_latency", lat <= 1, 1'b1);
        chk("t4_done", done_cnt, 1);

        // start while busy is ignored
        build_exp(16'h0000, 17);
        run_dump(16'h0000, 16'd17, -1, 5, lat);
        cmp_stream("t5");
        chk("t5_done", done_cnt, 1);

        // address wrap
        mem[16'hFFFF] = 8'h12; mem[0] = 8'h34;
        build_exp(16'hFFFF, 2);
        run_dump(16'hFFFF, 16'd2, -1, -1, lat);
        cmp_stream("t6");
`ifndef DEV_DUMPER_ADDR_PREFIX_EN
        for (int i = 0; i < 6; i++) chk($sformatf("t6_lit[%0d]", i), cap[i], lit6[i]);
`endif

        // reset mid-dump aborts silently
        cap.delete();
        done_cnt = 0;
        @(negedge clk);
        base_addr = 16'h0000;
        len       = 16'd17;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t7_busy_pre", busy, 1'b1);
        snap_n = cap.size();
        rst_n  = 1'b0;
        #1;
        chk("t7_push", tx_push, 1'b0);
        chk("t7_busy", busy, 1'b0);
        chk("t7_fetch", ram_fetch, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t7_nopush", cap.size(), snap_n);
        chk("t7_nodone", done_cnt, 0);
        chk("t7_idle", busy, 1'b0);

`ifdef DEV_DUMPER_ADDR_PREFIX_EN
        mem[16'h0010] = 8'hAB; mem[16'h0011] = 8'hCD;
        run_dump(16'h0010, 16'd2, -1, -1, lat);
        chk("tp_len", cap.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("tp_lit[%0d]", i), cap[i], litp[i]);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
